// File: rtl/spi_mstr16_core.sv
// 16-bit mode-3 SPI master: one full-duplex frame per accepted wrt, MSB first.
// SCLK is the divider MSB; the frame starts and ends with SCLK high.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | SS_n high, divider parked at PRE, waiting for wrt
// FRONT | SS_n low, SCLK high for the front porch until the first fall
// SHIFT | 16 bit periods: sample MISO at RISE, shift at FALL
module spi_mstr16_core #(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [DIV_W-1:0] PRE  = {1'b1, 1'b0, {(DIV_W-2){1'b1}}};
  localparam logic [DIV_W-1:0] FALL = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] RISE = {1'b0, {(DIV_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [15:0]      shft, shft_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic             ss_n_nxt, done_nxt;
  logic             miso_smpl, miso_smpl_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= PRE;
      shft      <= '0;
      bit_cnt   <= '0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
      miso_smpl <= 1'b0;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      shft      <= shft_nxt;
      bit_cnt   <= bit_cnt_nxt;
      SS_n      <= ss_n_nxt;
      done      <= done_nxt;
      miso_smpl <= miso_smpl_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    div_nxt       = div;
    shft_nxt      = shft;
    bit_cnt_nxt   = bit_cnt;
    ss_n_nxt      = SS_n;
    done_nxt      = done;
    miso_smpl_nxt = miso_smpl;

    case (state)
      IDLE: begin
        div_nxt = PRE;
        if (wrt) begin
          shft_nxt    = cmd;
          ss_n_nxt    = 1'b0;
          done_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = FRONT;
        end
      end

      FRONT: begin
        div_nxt = div + 1'b1;
        if (div == FALL)
          state_nxt = SHIFT;
      end

      SHIFT: begin
        div_nxt = div + 1'b1;
        if (div == RISE)
          miso_smpl_nxt = MISO;
        if (div == FALL) begin
          shft_nxt = {shft[14:0], miso_smpl};
          // Last shift parks the divider so SCLK never makes a 17th fall.
          if (bit_cnt == 4'd15) begin
            div_nxt   = PRE;
            ss_n_nxt  = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign SCLK    = div[DIV_W-1];
  assign MOSI    = shft[15];
  assign rd_data = shft;

endmodule

// File: tb/tb_spi_mstr16_core.sv
// Bench for spi_mstr16_core: a mode-3 slave model plus a pin monitor, checked
// against frame rules (MSB-first bit streams, 16/16 SCLK phases, fixed latency).
module tb_spi_mstr16_core;

  localparam int DIV_W    = 5;
  localparam int PERIOD   = 2 ** DIV_W;
  localparam int HALF     = PERIOD / 2;
  localparam int LAT      = 2 ** (DIV_W - 2) + 16 * PERIOD + 1;
  localparam int FIRST_FALL = LAT - 16 * PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt = 1'b0;
  logic [15:0] cmd = '0;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;

  int checks   = 0;
  int failures = 0;

  spi_mstr16_core #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // Pin monitor and slave: everything observed on the falling clk edge.
  logic [15:0] slave_word = '0;
  int   cyc = 0;
  logic ss_prev = 1'b1, sclk_prev = 1'b1, done_prev = 1'b0;
  int   ss_fall_t = 0, ss_rise_t = 0, done_t = 0, done_cnt = 0;
  int   idle_toggles = 0, bit_idx = 0;
  int   rise_t[$];
  int   fall_t[$];
  logic mosi_q[$];

  always @(negedge clk) begin
    cyc++;
    if (SS_n === 1'b0 && ss_prev === 1'b1) begin
      ss_fall_t = cyc;
      rise_t.delete();
      fall_t.delete();
      mosi_q.delete();
      done_cnt = 0;
      bit_idx  = 0;
    end
    if (SS_n === 1'b1 && ss_prev === 1'b0)
      ss_rise_t = cyc;
    if (SCLK !== sclk_prev) begin
      if (ss_prev === 1'b1 && SS_n === 1'b1)
        idle_toggles++;
      else if (SS_n === 1'b0) begin
        if (SCLK === 1'b1) begin
          rise_t.push_back(cyc);
          mosi_q.push_back(MOSI);
        end else begin
          fall_t.push_back(cyc);
          if (bit_idx < 16)
            MISO = slave_word[15 - bit_idx];
          bit_idx++;
        end
      end
    end
    if (done === 1'b1 && done_prev === 1'b0) begin
      done_t = cyc;
      done_cnt++;
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] c, input logic [15:0] sw);
    slave_word = sw;
    cmd = c;
    wrt = 1'b1;
    tick();
    wrt = 1'b0;
    cmd = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " done_seen"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] c, input logic [15:0] sw);
    logic [15:0] w;
    int phase_err;
    w = '0;
    foreach (mosi_q[i]) w = {w[14:0], mosi_q[i]};
    check({tag, " mosi_bits"}, mosi_q.size(), 16);
    check({tag, " mosi_word"}, {16'b0, w}, {16'b0, c});
    check({tag, " rd_data"}, {16'b0, rd_data}, {16'b0, sw});
    check({tag, " latency"}, done_t - ss_fall_t, LAT);
    check({tag, " ss_rise_with_done"}, ss_rise_t, done_t);
    check({tag, " ss_n_high"}, {31'b0, SS_n}, 32'd1);
    check({tag, " sclk_high"}, {31'b0, SCLK}, 32'd1);
    check({tag, " falls"}, fall_t.size(), 16);
    check({tag, " rises"}, rise_t.size(), 16);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " idle_toggles"}, idle_toggles, 0);
    if (fall_t.size() == 16 && rise_t.size() == 16) begin
      phase_err = 0;
      for (int i = 0; i < 16; i++) begin
        if (rise_t[i] - fall_t[i] != HALF) phase_err++;
        if (i < 15 && fall_t[i+1] - rise_t[i] != HALF) phase_err++;
      end
      check({tag, " phase_errors"}, phase_err, 0);
      check({tag, " first_fall"}, fall_t[0] - ss_fall_t, FIRST_FALL);
      check({tag, " tail_high"}, {31'b0, (ss_rise_t - rise_t[15]) >= 1}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] c, sw, held;

    tick();
    tick();
    check("reset ss_n", {31'b0, SS_n}, 32'd1);
    check("reset sclk", {31'b0, SCLK}, 32'd1);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset rd_data", {16'b0, rd_data}, 32'd0);
    check("reset mosi", {31'b0, MOSI}, 32'd0);
    rst = 1'b0;
    repeat (100) tick();
    check("idle ss_n", {31'b0, SS_n}, 32'd1);
    check("idle sclk", {31'b0, SCLK}, 32'd1);
    check("idle done", {31'b0, done}, 32'd0);
    check("idle mosi", {31'b0, MOSI}, 32'd0);
    check("idle toggles", idle_toggles, 0);

    start_frame(16'hA2A5, 16'h00C5);
    check("start done_low", {31'b0, done}, 32'd0);
    wait_done("f1");
    check_frame("f1", 16'hA2A5, 16'h00C5);

    // Back-to-back: wrt on the first cycle done is seen high.
    held = rd_data;
    start_frame(16'h0D02, 16'h5A3C);
    check("b2b rd_data_held", {16'b0, held}, 32'h00C5);
    check("b2b done_clears", {31'b0, done}, 32'd0);
    wait_done("f2");
    check_frame("f2", 16'h0D02, 16'h5A3C);
    repeat (20) tick();
    check("f2 rd_data_stable", {16'b0, rd_data}, 32'h5A3C);

    for (int k = 0; k < 3; k++) begin
      c  = 16'($urandom);
      sw = 16'($urandom);
      start_frame(c, sw);
      wait_done("rnd");
      check_frame("rnd", c, sw);
      repeat (1 + $urandom_range(0, 5)) tick();
    end

    // wrt while busy must be ignored.
    start_frame(16'h1053, 16'hBEEF);
    repeat (100) tick();
    cmd = 16'hFFFF;
    wrt = 1'b1;
    tick();
    wrt = 1'b0;
    wait_done("busy");
    check_frame("busy", 16'h1053, 16'hBEEF);
    repeat (50) tick();
    check("busy no_second_frame", {31'b0, SS_n}, 32'd1);
    check("busy single_done", done_cnt, 1);

    // Reset in the middle of bit 7 (SCLK low).
    start_frame(16'hC3A1, 16'h7E81);
    begin
      int n = 0;
      while (fall_t.size() < 8 && n < 2000) begin
        tick();
        n++;
      end
    end
    check("rstmid reached_bit7", fall_t.size(), 8);
    check("rstmid sclk_low_before", {31'b0, SCLK}, 32'd0);
    rst = 1'b1;
    tick();
    check("rstmid ss_n", {31'b0, SS_n}, 32'd1);
    check("rstmid sclk", {31'b0, SCLK}, 32'd1);
    check("rstmid done", {31'b0, done}, 32'd0);
    check("rstmid rd_data", {16'b0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    check("rstmid no_done", {31'b0, done}, 32'd0);
    check("rstmid idle_toggles", idle_toggles, 0);
    c  = 16'($urandom);
    sw = 16'($urandom);
    start_frame(c, sw);
    wait_done("after_rst");
    check_frame("after_rst", c, sw);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
